// File: rtl/arty_reset_sequencer.sv
// Board-level reset sequencer: waits for MMCM lock, holds reset, re-issues on button press or lock loss.
// Optional: define RESET_SEQ_LOCK_QUALIFY_EN to require 16 consecutive locked samples before leaving S_WAIT_LOCK.
module arty_reset_sequencer #(
    parameter int c_HOLD_CYCLES     = 1000,
    parameter int c_DEBOUNCE_CYCLES = 20000
) (
    input  logic       i_clk_mhz,
    input  logic       i_rstn_global,
    input  logic       i_mmcm_locked,
    input  logic       i_btn_rst,
    output logic       o_rstn_out,
    output logic       o_rst_busy,
    output logic [7:0] o_rst_count
);
    localparam int c_HW = $clog2(c_HOLD_CYCLES + 1);
    localparam int c_DW = $clog2(c_DEBOUNCE_CYCLES);
    // The entry edge plus c_HOLD_CYCLES counted edges gives the c_HOLD_CYCLES+1 latency to S_RUN.
    localparam logic [c_HW-1:0] c_HOLD_LAST = c_HW'(c_HOLD_CYCLES);
    localparam logic [c_DW-1:0] c_DB_LAST   = c_DW'(c_DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_HOLD      = 2'd1,
        S_RUN       = 2'd2
    } state_t;

    state_t            r_state;
    logic [c_HW-1:0]   r_hold_cnt;
    logic              r_lock_meta;
    logic              r_lock_sync;
    logic              r_btn_meta;
    logic              r_btn_sync;
    logic              r_btn_stable;
    logic [c_DW-1:0]   r_db_cnt;
    logic              r_press;
    logic              r_rstn_out;
    logic              r_rst_busy;
    logic [7:0]        r_rst_count;
`ifdef RESET_SEQ_LOCK_QUALIFY_EN
    logic [3:0]        r_qual_cnt;
`endif

    always_ff @(posedge i_clk_mhz) begin
        if (!i_rstn_global) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
            r_btn_meta  <= 1'b0;
            r_btn_sync  <= 1'b0;
        end else begin
            r_lock_meta <= i_mmcm_locked;
            r_lock_sync <= r_lock_meta;
            r_btn_meta  <= i_btn_rst;
            r_btn_sync  <= r_btn_meta;
        end
    end

    // Debounce; r_press pulses for one cycle only when the stable value goes 0->1.
    always_ff @(posedge i_clk_mhz) begin
        if (!i_rstn_global) begin
            r_btn_stable <= 1'b0;
            r_db_cnt     <= '0;
            r_press      <= 1'b0;
        end else if (r_btn_sync == r_btn_stable) begin
            r_db_cnt <= '0;
            r_press  <= 1'b0;
        end else if (r_db_cnt == c_DB_LAST) begin
            r_btn_stable <= r_btn_sync;
            r_db_cnt     <= '0;
            r_press      <= r_btn_sync;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
            r_press  <= 1'b0;
        end
    end

    always_ff @(posedge i_clk_mhz) begin
        if (!i_rstn_global) begin
            r_state     <= S_WAIT_LOCK;
            r_hold_cnt  <= '0;
            r_rstn_out  <= 1'b0;
            r_rst_busy  <= 1'b1;
            r_rst_count <= 8'd0;
`ifdef RESET_SEQ_LOCK_QUALIFY_EN
            r_qual_cnt  <= 4'd0;
`endif
        end else begin
            case (r_state)
                S_WAIT_LOCK: begin
`ifdef RESET_SEQ_LOCK_QUALIFY_EN
                    if (!r_lock_sync) begin
                        r_qual_cnt <= 4'd0;
                    end else if (r_qual_cnt == 4'hF) begin
                        r_qual_cnt <= 4'd0;
                        r_state    <= S_HOLD;
                        r_hold_cnt <= '0;
                    end else begin
                        r_qual_cnt <= r_qual_cnt + 4'd1;
                    end
`else
                    if (r_lock_sync) begin
                        r_state    <= S_HOLD;
                        r_hold_cnt <= '0;
                    end
`endif
                end
                S_HOLD: begin
                    if (!r_lock_sync) begin
                        r_state <= S_WAIT_LOCK;
                    end else if (r_hold_cnt == c_HOLD_LAST) begin
                        r_state    <= S_RUN;
                        r_rstn_out <= 1'b1;
                        r_rst_busy <= 1'b0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    // Lock loss outranks a press; either way exactly one count per exit.
                    if (!r_lock_sync || r_press) begin
                        r_state     <= r_lock_sync ? S_HOLD : S_WAIT_LOCK;
                        r_hold_cnt  <= '0;
                        r_rstn_out  <= 1'b0;
                        r_rst_busy  <= 1'b1;
                        if (r_rst_count != 8'hFF) r_rst_count <= r_rst_count + 8'd1;
                    end
                end
                default: begin
                    r_state    <= S_WAIT_LOCK;
                    r_rstn_out <= 1'b0;
                    r_rst_busy <= 1'b1;
                end
            endcase
        end
    end

    assign o_rstn_out  = r_rstn_out;
    assign o_rst_busy  = r_rst_busy;
    assign o_rst_count = r_rst_count;
endmodule

// File: tb/tb_arty_reset_sequencer.sv
// Scoreboard bench: stimulus queues expected output transitions, a negedge monitor matches each change.
module tb_arty_reset_sequencer;
    localparam int H = 8;
    localparam int D = 4;
`ifdef RESET_SEQ_LOCK_QUALIFY_EN
    localparam int LAT = 16 + H;
`else
    localparam int LAT = H + 1;
`endif
    localparam int PRESS_LAT = H + 1;

    typedef struct {
        int         cyc;
        logic       rstn;
        logic       busy;
        logic [7:0] cnt;
    } exp_t;

    logic       clk;
    logic       rstn_global;
    logic       mmcm_locked;
    logic       btn_rst;
    logic       rstn_out;
    logic       rst_busy;
    logic [7:0] rst_count;

    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic       mon_en = 1'b0;
    logic [9:0] prev;
    logic [9:0] cur;
    logic [7:0] exp_cnt = 8'd0;

    arty_reset_sequencer #(.c_HOLD_CYCLES(H), .c_DEBOUNCE_CYCLES(D)) dut (
        .i_clk_mhz    (clk),
        .i_rstn_global(rstn_global),
        .i_mmcm_locked(mmcm_locked),
        .i_btn_rst    (btn_rst),
        .o_rstn_out   (rstn_out),
        .o_rst_busy   (rst_busy),
        .o_rst_count  (rst_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Every output change must match the head of the expectation queue, including its edge number.
    always @(negedge clk) begin
        if (!mon_en) begin
            prev = {1'b0, 1'b1, 8'h00};
        end else begin
            cur = {rstn_out, rst_busy, rst_count};
            if (cur !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change cyc=%0d got rstn=%b busy=%b cnt=%0d want no change",
                             cyc, rstn_out, rst_busy, rst_count);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || cur !== {e.rstn, e.busy, e.cnt}) begin
                        failures++;
                        $display("FAIL transition got cyc=%0d rstn=%b busy=%b cnt=%0d want cyc=%0d rstn=%b busy=%b cnt=%0d",
                                 cyc, rstn_out, rst_busy, rst_count, e.cyc, e.rstn, e.busy, e.cnt);
                    end
                end
                prev = cur;
            end
        end
    end

    function automatic void push(input int c, input logic r, input logic b, input logic [7:0] n);
        exp_t e;
        e.cyc = c; e.rstn = r; e.busy = b; e.cnt = n;
        exp_q.push_back(e);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, act, req);
        end
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input int budget, input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout got pending=%0d want 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    // One-clock lock drop while in S_RUN: falls 3 edges later, rises LAT after sync sees lock again.
    task automatic lock_blip();
        int k;
        @(negedge clk);
        k = cyc;
        mmcm_locked = 1'b0;
        exp_cnt = sat_inc(exp_cnt);
        push(k + 3, 1'b0, 1'b1, exp_cnt);
        @(negedge clk);
        mmcm_locked = 1'b1;
        push(k + 4 + LAT, 1'b1, 1'b0, exp_cnt);
    endtask

    initial begin
        int k;
        rstn_global = 1'b0;
        mmcm_locked = 1'b1;
        btn_rst     = 1'b0;
        nclk(3);
        chk("reset_rstn", {7'd0, rstn_out}, 8'd0);
        chk("reset_busy", {7'd0, rst_busy}, 8'd1);
        chk("reset_count", rst_count, 8'd0);
        mon_en = 1'b1;

        // Power-up release
        k = cyc;
        rstn_global = 1'b1;
        push(k + 3 + LAT, 1'b1, 1'b0, 8'd0);
        drain(LAT + 20, "powerup");

        // Lock loss in S_RUN
        lock_blip();
        drain(LAT + 20, "lockloss");

        // Bouncy press: never 4 consecutive differing samples, then a clean hold
        nclk(1);
        for (int i = 0; i < 5; i++) begin
            btn_rst = 1'b1; nclk(2);
            btn_rst = 1'b0; nclk(2);
        end
        k = cyc;
        btn_rst = 1'b1;
        exp_cnt = sat_inc(exp_cnt);
        push(k + 7, 1'b0, 1'b1, exp_cnt);
        push(k + 7 + PRESS_LAT, 1'b1, 1'b0, exp_cnt);
        nclk(10);
        btn_rst = 1'b0;
        drain(40, "press");
        nclk(10);
        // Short glitch
        btn_rst = 1'b1; nclk(3);
        btn_rst = 1'b0; nclk(15);
        chk("glitch_count", rst_count, exp_cnt);
        chk("glitch_rstn", {7'd0, rstn_out}, 8'd1);

        // Press while holding is ignored
        lock_blip();
        btn_rst = 1'b1; nclk(6);
        btn_rst = 1'b0;
        drain(LAT + 20, "hold_press");
        nclk(10);
        chk("hold_press_count", rst_count, exp_cnt);

        // Lock drop and press seen on the same edge
        nclk(1);
        k = cyc;
        btn_rst = 1'b1;
        nclk(4);
        mmcm_locked = 1'b0;
        exp_cnt = sat_inc(exp_cnt);
        push(k + 7, 1'b0, 1'b1, exp_cnt);
        nclk(1);
        mmcm_locked = 1'b1;
        push(k + 8 + LAT, 1'b1, 1'b0, exp_cnt);
        nclk(3);
        btn_rst = 1'b0;
        drain(LAT + 20, "simul");
        nclk(10);
        chk("simul_count", rst_count, 8'd4);

        // Global reset mid-run with count=5
        lock_blip();
        drain(LAT + 20, "fifth");
        chk("pre_rst_count", rst_count, 8'd5);
        nclk(1);
        k = cyc;
        rstn_global = 1'b0;
        exp_cnt = 8'd0;
        push(k + 1, 1'b0, 1'b1, 8'd0);
        nclk(1);
        rstn_global = 1'b1;
        chk("midrun_rst_count", rst_count, 8'd0);
        chk("midrun_rst_rstn", {7'd0, rstn_out}, 8'd0);
        push(k + 4 + LAT, 1'b1, 1'b0, 8'd0);
        drain(LAT + 20, "rerelease");

        // Saturation
        for (int i = 0; i < 260; i++) begin
            lock_blip();
            drain(LAT + 20, "sat");
        end
        chk("sat_count", rst_count, 8'd255);

`ifdef RESET_SEQ_LOCK_QUALIFY_EN
        // A lock toggling every 10 clocks never qualifies
        nclk(1);
        k = cyc;
        mmcm_locked = 1'b0;
        push(k + 3, 1'b0, 1'b1, exp_cnt);
        for (int i = 0; i < 5; i++) begin
            nclk(10); mmcm_locked = 1'b1;
            nclk(10); mmcm_locked = 1'b0;
        end
        drain(10, "qualify");
        nclk(20);
        chk("qualify_rstn", {7'd0, rstn_out}, 8'd0);
`endif

        drain(5, "final");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        failures++;
        $display("FAIL watchdog got time limit want completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
